// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: state encoding,
// store-size strobe codes and the fixed word load-size code used for fetches.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_D  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        BUSY_IF = ST_BUSY_IF,
        BUSY_D  = ST_BUSY_D,
        DONE    = ST_DONE
    } arb_state_t;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Counts BUSY cycles of one memory transaction; hit fires during the
// TIMEOUT-th enabled cycle so the arbiter can abort on that same edge.
module wait_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CW'(TIMEOUT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of BUSY cycles already completed
    assign hit = enable && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store,
// sequencing one latched transaction at a time with fixed data priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_memwrite,
    input  logic [2:0]    d_sizeload,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_we,
    output logic [2:0]    mem_size,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          timeout_err
);

    arb_state_t    state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]    mem_we_q, mem_we_d;
    logic [2:0]    mem_size_q, mem_size_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          owner_data_q, owner_data_d;
    logic          timeout_err_q, timeout_err_d;
    logic          busy;
    logic          hit;

    assign busy = (state_q == BUSY_IF) || (state_q == BUSY_D);

    wait_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == DONE),
        .enable(busy),
        .hit   (hit)
    );

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = mem_we_q;
        mem_size_d    = mem_size_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        owner_data_d  = owner_data_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                    mem_we_d     = d_memwrite;
                    mem_size_d   = d_sizeload;
                    owner_data_d = 1'b1;
                    state_d      = BUSY_D;
                end else if (if_req) begin
                    mem_addr_d   = if_addr;
                    mem_we_d     = MW_NONE;
                    mem_size_d   = SIZE_WORD;
                    owner_data_d = 1'b0;
                    state_d      = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                // a completing access wins over a timeout in the same cycle
                if (mem_ready) begin
                    if (owner_data_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (hit) begin
                    if (owner_data_q) begin
                        d_rdata_d = '0;
                    end else begin
                        if_rdata_d = '0;
                    end
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= MW_NONE;
            mem_size_q    <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            owner_data_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            mem_size_q    <= mem_size_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            owner_data_q  <= owner_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // strobes decode from the state register so an async reset kills them at once
    assign mem_req     = busy;
    assign if_ack      = (state_q == DONE) && !owner_data_q;
    assign d_ack       = (state_q == DONE) && owner_data_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_size    = mem_size_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign timeout_err = timeout_err_q;
    assign stall       = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory with per-transaction
// ready delay, expected grants and acks queued when requests are driven.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   typedef struct {
      logic        isData;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  we;
      logic [2:0]  size;
      logic [31:0] rdata;
      int          delay;
   } txn_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          d_req;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [1:0]    d_memwrite;
   logic [2:0]    d_sizeload;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [1:0]    mem_we;
   logic [2:0]    mem_size;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic          stall;
   logic          timeout_err;

   int errors = 0;
   int checks = 0;
   int cycleCount = 0;
   int lastBusyLen = 0;
   int lastIfAckCycle = -1;
   bit spacingOn = 0;
   bit tieReady = 0;
   bit idlePulse = 0;

   txn_t        memQ[$];
   logic [31:0] ifQ[$];
   logic [31:0] dQ[$];

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   mem_arbiter #(
      .AW(AW),
      .DW(DW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_rdata(if_rdata),
      .if_ack(if_ack),
      .d_req(d_req),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_memwrite(d_memwrite),
      .d_sizeload(d_sizeload),
      .d_rdata(d_rdata),
      .d_ack(d_ack),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we(mem_we),
      .mem_size(mem_size),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .stall(stall),
      .timeout_err(timeout_err)
   );

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] memData(input logic [31:0] a);
      if (a == 32'h40) return 32'h0050_0093;
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic txn_t mkTxn(input logic isData, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] we, input logic [2:0] size, input int delay,
                                  input logic [31:0] rdata);
      txn_t t;
      t.isData = isData;
      t.addr   = addr;
      t.wdata  = wdata;
      t.we     = we;
      t.size   = size;
      t.delay  = delay;
      t.rdata  = rdata;
      return t;
   endfunction

   // Grants are queued in the order the arbiter is expected to issue them
   task automatic expectGrant(input txn_t t);
      memQ.push_back(t);
   endtask

   // Raise one request, queue its expected ack data, hold until the ack is seen
   task automatic applyStimulus(input txn_t t);
      bit got;
      got = 0;
      if (t.isData) begin
         dQ.push_back(t.rdata);
         d_req      = 1'b1;
         d_addr     = t.addr;
         d_wdata    = t.wdata;
         d_memwrite = t.we;
         d_sizeload = t.size;
      end else begin
         ifQ.push_back(t.rdata);
         if_req  = 1'b1;
         if_addr = t.addr;
      end
      for (int n = 0; n < 60 && !got; n++) begin
         @(negedge clk);
         got = t.isData ? d_ack : if_ack;
      end
      if (!got) checkOutput(t.isData ? "d_ack_wait" : "if_ack_wait", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (t.isData) d_req = 1'b0;
      else if_req = 1'b0;
   endtask

   // Behavioural memory: checks each new grant against the expected queue,
   // then answers after the transaction's ready delay (negative = never)
   initial begin
      txn_t cur;
      bit   prevReq;
      int   busyCnt;
      prevReq = 0;
      busyCnt = 0;
      cur = mkTxn(0, 0, 0, MW_NONE, 3'b000, -1, 0);
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req && !prevReq) begin
            busyCnt = 0;
            if (memQ.size() == 0) begin
               checkOutput("grant_unexpected", 32'd1, 32'd0);
               cur.delay = 0;
            end else begin
               cur = memQ.pop_front();
               checkOutput("mem_addr", mem_addr, cur.addr);
               checkOutput("mem_we", 32'(mem_we), 32'(cur.we));
               checkOutput("mem_size", 32'(mem_size), 32'(cur.size));
               if (cur.we != MW_NONE) checkOutput("mem_wdata", mem_wdata, cur.wdata);
            end
         end
         if (!mem_req && prevReq) lastBusyLen = busyCnt;
         if (mem_req) begin
            mem_ready = tieReady || (cur.delay >= 0 && busyCnt == cur.delay);
            busyCnt++;
         end else begin
            mem_ready = tieReady || idlePulse;
         end
         mem_rdata = memData(mem_addr);
         prevReq = mem_req;
      end
   end

   // Ack monitor: every ack pops the matching port's expected read data
   initial begin
      forever begin
         @(negedge clk);
         if (if_ack) begin
            if (ifQ.size() == 0) checkOutput("if_ack_unexpected", 32'd1, 32'd0);
            else checkOutput("if_rdata", if_rdata, ifQ.pop_front());
            if (spacingOn && lastIfAckCycle >= 0)
               checkOutput("if_ack_spacing", 32'(cycleCount - lastIfAckCycle), 32'd3);
            lastIfAckCycle = cycleCount;
         end
         if (d_ack) begin
            if (dQ.size() == 0) checkOutput("d_ack_unexpected", 32'd1, 32'd0);
            else checkOutput("d_rdata", d_rdata, dQ.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      txn_t t;
      txn_t t2;
      bit   seenAck;
      reset = 1'b1;
      if_req = 1'b0;
      if_addr = '0;
      d_req = 1'b0;
      d_addr = '0;
      d_wdata = '0;
      d_memwrite = MW_NONE;
      d_sizeload = 3'b000;
      #1;
      $display("[TB] reset state");
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_mem_size", 32'(mem_size), 32'd0);
      checkOutput("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
      checkOutput("rst_if_rdata", if_rdata, 32'd0);
      checkOutput("rst_d_rdata", d_rdata, 32'd0);
      checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] fetch only, ready two cycles after grant");
      t = mkTxn(0, 32'h40, 0, MW_NONE, SIZE_WORD, 2, 32'h0050_0093);
      expectGrant(t);
      applyStimulus(t);
      checkOutput("fetch_busy_len", 32'(lastBusyLen), 32'd3);

      $display("[TB] simultaneous fetch and store");
      t  = mkTxn(1, 32'h100, 32'hDEAD_BEEF, MW_WORD, 3'b010, 0, memData(32'h100));
      t2 = mkTxn(0, 32'h44, 0, MW_NONE, SIZE_WORD, 1, memData(32'h44));
      expectGrant(t);
      expectGrant(t2);
      fork
         applyStimulus(t);
         applyStimulus(t2);
         begin
            seenAck = 0;
            for (int n = 0; n < 40 && !seenAck; n++) begin
               @(negedge clk);
               if (if_ack) begin
                  checkOutput("stall_at_if_ack", 32'(stall), 32'd0);
                  seenAck = 1;
               end else begin
                  checkOutput("stall_pending", 32'(stall), 32'd1);
               end
            end
         end
      join

      $display("[TB] back-to-back fetches, ready tied high");
      tieReady = 1;
      spacingOn = 1;
      lastIfAckCycle = -1;
      for (int i = 0; i < 4; i++) begin
         t = mkTxn(0, 32'h1000 + 32'(i * 4), 0, MW_NONE, SIZE_WORD, 0, memData(32'h1000 + 32'(i * 4)));
         expectGrant(t);
         applyStimulus(t);
      end
      spacingOn = 0;
      tieReady = 0;

      $display("[TB] load with no ready -> timeout");
      t = mkTxn(1, 32'h200, 0, MW_NONE, 3'b010, -1, 32'h0);
      expectGrant(t);
      applyStimulus(t);
      checkOutput("timeout_busy_len", 32'(lastBusyLen), 32'(TO));
      checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);

      t = mkTxn(0, 32'h80, 0, MW_NONE, SIZE_WORD, 3, memData(32'h80));
      expectGrant(t);
      applyStimulus(t);
      t = mkTxn(1, 32'h204, 32'h0000_00A5, MW_BYTE, 3'b000, 1, memData(32'h204));
      expectGrant(t);
      applyStimulus(t);
      checkOutput("timeout_err_sticky", 32'(timeout_err), 32'd1);

      $display("[TB] ready pulse while idle");
      idlePulse = 1;
      @(negedge clk);
      #1;
      idlePulse = 0;
      repeat (3) @(negedge clk);
      checkOutput("idle_state", 32'(dut.state_q), 32'(IDLE));
      checkOutput("idle_if_rdata", if_rdata, memData(32'h80));
      checkOutput("idle_d_rdata", d_rdata, memData(32'h204));
      checkOutput("idle_mem_req", 32'(mem_req), 32'd0);

      $display("[TB] async reset during BUSY_D");
      @(posedge clk);
      #1;
      t = mkTxn(1, 32'h300, 0, MW_NONE, 3'b100, -1, 32'h0);
      expectGrant(t);
      d_req = 1'b1;
      d_addr = 32'h300;
      d_memwrite = MW_NONE;
      d_sizeload = 3'b100;
      repeat (2) @(negedge clk);
      checkOutput("busy_before_reset", 32'(mem_req), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset_d_ack", 32'(d_ack), 32'd0);
      checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
      d_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_reset_state", 32'(dut.state_q), 32'(IDLE));
      repeat (3) @(negedge clk);
      checkOutput("post_reset_mem_req", 32'(mem_req), 32'd0);
      checkOutput("memQ_drained", 32'(memQ.size()), 32'd0);
      checkOutput("ifQ_drained", 32'(ifQ.size()), 32'd0);
      checkOutput("dQ_drained", 32'(dQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch path and its load/store path. The store-size and load-size codes produced by the instruction decoder are forwarded to the memory. Requests are latched, one transaction is sequenced at a time, read data is returned with a one-cycle ack, and a stall is raised while any request is outstanding. A cycle timeout aborts a hung transaction and sets a sticky error flag.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max BUSY cycles without mem_ready before abort (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch request; held until if_ack sampled high
if_addr  input  AW  fetch address
if_rdata  output  DW  fetched word, valid while if_ack=1
if_ack  output  1  one-cycle fetch completion pulse
d_req  input  1  load/store request; held until d_ack sampled high
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_memwrite  input  2  store size: 00 none (load), 01 byte, 10 half, 11 word
d_sizeload  input  3  load size/sign code (funct3 encoding)
d_rdata  output  DW  load data, valid while d_ack=1
d_ack  output  1  one-cycle data completion pulse
mem_req  output  1  memory transaction active
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_we  output  2  memory write-size strobe, same encoding as d_memwrite
mem_size  output  3  memory load-size code
mem_ready  input  1  memory completes current transaction this cycle
mem_rdata  input  DW  memory read data, valid with mem_ready
stall  output  1  core stall
timeout_err  output  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY_IF, BUSY_D, DONE. On reset (async): state=IDLE; mem_req=0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; mem_we=00; mem_size=000; acks=0; timeout_err=0; counter=0.
- IDLE: if d_req, latch d_addr/d_wdata/d_memwrite/d_sizeload, go BUSY_D. Else if if_req, latch if_addr, force we=00, size=010 (word), go BUSY_IF. Data has fixed priority on a simultaneous request.
- BUSY_*: mem_req=1 with latched outputs stable. Counter increments each BUSY cycle.
- mem_ready=1 in BUSY_*: capture mem_rdata into the owning rdata register, go DONE.
- Counter reaching TIMEOUT without mem_ready: owning rdata=0, timeout_err<=1, go DONE.
- DONE: mem_req=0; owning ack=1 for exactly this cycle; requests are not sampled; counter cleared; next state IDLE.
- Requesters drop req at the edge ending DONE, so a served request is never regranted.
- Latency: request in IDLE at cycle N, mem_req high at N+1. If mem_ready is sampled at cycle M, ack is high at M+1. Minimum 3 cycles per transaction; one IDLE bubble between back-to-back transactions.
- mem_ready is ignored in IDLE and DONE.
- rdata registers hold their value until the next capture.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
- timeout_err is cleared only by reset.
- Reset mid-transaction: mem_req drops immediately; the in-flight access is abandoned and no ack is issued.

Decomposition:
- Shared package:
  - State encoding localparams.
  - MemWrite codes MW_NONE/MW_BYTE/MW_HALF/MW_WORD.
  - SIZE_WORD=3'b010.
- Sub-module wait_counter: clear and enable inputs, hit output at TIMEOUT, width $clog2(TIMEOUT+1).

Test Plan:
- Fetch only: if_req=1, if_addr=0x40. mem_ready asserted 2 cycles after mem_req rises, mem_rdata=0x00500093 -> mem_we=00, mem_size=010, mem_addr=0x40; one cycle later if_ack=1, if_rdata=0x00500093.
- Simultaneous requests: if_req addr 0x44; d_req store addr 0x100, wdata 0xDEADBEEF, memwrite=11 -> store issued first with mem_we=11, then fetch; stall=1 until the fetch ack cycle, then 0.
- mem_ready tied high, fetch requests issued back-to-back -> exactly one ack per 3 cycles; mem_addr follows each latched if_addr.
- TIMEOUT=4, load at 0x200, mem_ready held low -> after 4 BUSY cycles d_ack=1, d_rdata=0, timeout_err=1; it stays 1 through later successful transactions.
- Reset asserted asynchronously in BUSY_D -> mem_req, d_ack and timeout_err go 0 before the next edge; state is IDLE after release.
- mem_ready pulsed in IDLE with no request -> no ack, state stays IDLE, rdata unchanged.
